// File: rtl/eth_tx_fcs_insert.sv
// Byte-wide Ethernet TX stage: forwards payload, optionally zero-pads short frames
// and appends the reflected CRC-32 FCS through a single-entry output register.
module eth_tx_fcs_insert #(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] s_tdata_i,
  input  logic       s_tvalid_i,
  input  logic       s_tlast_i,
  output logic       s_tready_o,
  output logic [7:0] m_tdata_o,
  output logic       m_tvalid_o,
  output logic       m_tlast_o,
  input  logic       m_tready_i
);

  localparam logic [31:0] POLY_REFL = 32'hEDB88320;
  localparam logic [COUNT_WIDTH:0] PAD_TARGET = (COUNT_WIDTH+1)'(MIN_FRAME_LENGTH - 4);

  typedef enum logic [1:0] {ST_PAYLOAD, ST_PAD, ST_FCS} state_t;

  // Bit-serial reflected LFSR, used only at elaboration to derive the parallel masks.
  function automatic logic [31:0] lfsr_serial(input logic [31:0] s, input logic [7:0] d);
    logic [31:0] r;
    r = s;
    for (int k = 0; k < 8; k++) begin
      r = (r >> 1) ^ ((r[0] ^ d[k]) ? POLY_REFL : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [31:0][31:0] gen_mask_state();
    logic [31:0][31:0] m;
    logic [31:0]       col;
    m = '0;
    for (int j = 0; j < 32; j++) begin
      col = lfsr_serial(32'h1 << j, 8'h00);
      for (int i = 0; i < 32; i++) m[i][j] = col[i];
    end
    return m;
  endfunction

  function automatic logic [31:0][7:0] gen_mask_data();
    logic [31:0][7:0] m;
    logic [31:0]      col;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      col = lfsr_serial(32'h0, 8'h1 << j);
      for (int i = 0; i < 32; i++) m[i][j] = col[i];
    end
    return m;
  endfunction

  localparam logic [31:0][31:0] MASK_STATE = gen_mask_state();
  localparam logic [31:0][7:0]  MASK_DATA  = gen_mask_data();

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n[i] = (^(MASK_STATE[i] & c)) ^ (^(MASK_DATA[i] & b));
    end
    return n;
  endfunction

  state_t                 state_q;
  logic [31:0]            crc_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [1:0]             fcs_idx_q;
  logic [7:0]             m_tdata_q;
  logic                   m_tvalid_q;
  logic                   m_tlast_q;

  logic                   free;
  logic [7:0]             crc_byte;
  logic [31:0]            crc_d;
  logic [COUNT_WIDTH-1:0] count_d;
  logic [COUNT_WIDTH:0]   count_inc;
  logic                   pad_needed;
  logic                   pad_done;
  logic [31:0]            fcs_word;
  logic [7:0]             fcs_byte;

  assign free       = !m_tvalid_q || m_tready_i;
  assign crc_byte   = (state_q == ST_PAYLOAD) ? s_tdata_i : 8'h00;
  assign crc_d      = crc_step(crc_q, crc_byte);
  // count_inc is unsaturated so the pad comparison stays correct at the counter limit.
  assign count_inc  = {1'b0, count_q} + (COUNT_WIDTH+1)'(1);
  assign count_d    = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
  assign pad_needed = (ENABLE_PADDING != 0) && (count_inc < PAD_TARGET);
  assign pad_done   = (count_inc >= PAD_TARGET);
  assign fcs_word   = ~crc_q;
  assign fcs_byte   = fcs_word[{fcs_idx_q, 3'b000} +: 8];

  assign s_tready_o = reset_n_i && (state_q == ST_PAYLOAD) && free;
  assign m_tdata_o  = m_tdata_q;
  assign m_tvalid_o = m_tvalid_q;
  assign m_tlast_o  = m_tlast_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_PAYLOAD;
      crc_q      <= 32'hFFFFFFFF;
      count_q    <= '0;
      fcs_idx_q  <= 2'd0;
      m_tdata_q  <= 8'h00;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else if (free) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      case (state_q)
        ST_PAYLOAD: begin
          if (s_tvalid_i) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= s_tdata_i;
            crc_q      <= crc_d;
            count_q    <= count_d;
            if (s_tlast_i) begin
              fcs_idx_q <= 2'd0;
              state_q   <= pad_needed ? ST_PAD : ST_FCS;
            end
          end
        end
        ST_PAD: begin
          m_tvalid_q <= 1'b1;
          m_tdata_q  <= 8'h00;
          crc_q      <= crc_d;
          count_q    <= count_d;
          if (pad_done) begin
            fcs_idx_q <= 2'd0;
            state_q   <= ST_FCS;
          end
        end
        ST_FCS: begin
          m_tvalid_q <= 1'b1;
          m_tdata_q  <= fcs_byte;
          fcs_idx_q  <= fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            m_tlast_q <= 1'b1;
            crc_q     <= 32'hFFFFFFFF;
            count_q   <= '0;
            state_q   <= ST_PAYLOAD;
          end
        end
        default: state_q <= ST_PAYLOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_insert.sv
// Bench for eth_tx_fcs_insert: one unpadded and one padded instance, driven from a
// frame table plus back-to-back/backpressure and mid-frame reset sequences.
module tb_eth_tx_fcs_insert;

  localparam int MINLEN = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_tdata  [2];
  logic       s_tvalid [2];
  logic       s_tlast  [2];
  logic       s_tready [2];
  logic [7:0] m_tdata  [2];
  logic       m_tvalid [2];
  logic       m_tlast  [2];
  logic       m_tready [2];

  always #5 clk = ~clk;

  eth_tx_fcs_insert #(.ENABLE_PADDING(0), .MIN_FRAME_LENGTH(MINLEN), .COUNT_WIDTH(16)) u_nopad (
    .clk_i(clk), .reset_n_i(rst_n),
    .s_tdata_i(s_tdata[0]), .s_tvalid_i(s_tvalid[0]), .s_tlast_i(s_tlast[0]), .s_tready_o(s_tready[0]),
    .m_tdata_o(m_tdata[0]), .m_tvalid_o(m_tvalid[0]), .m_tlast_o(m_tlast[0]), .m_tready_i(m_tready[0])
  );

  eth_tx_fcs_insert #(.ENABLE_PADDING(1), .MIN_FRAME_LENGTH(MINLEN), .COUNT_WIDTH(16)) u_pad (
    .clk_i(clk), .reset_n_i(rst_n),
    .s_tdata_i(s_tdata[1]), .s_tvalid_i(s_tvalid[1]), .s_tlast_i(s_tlast[1]), .s_tready_o(s_tready[1]),
    .m_tdata_o(m_tdata[1]), .m_tvalid_o(m_tvalid[1]), .m_tlast_o(m_tlast[1]), .m_tready_i(m_tready[1])
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    int          dut;
    int          kind;
    int          len;
    logic [31:0] fcs_const;
    int          span;
    int          stall;
  } vec_t;

  beat_t q0[$];
  beat_t q1[$];
  vec_t  vecs[5];
  int    ncmp;
  int    nerr;
  int    cyc;
  logic  rand_rdy;
  int    first_cyc[2];
  int    last_span[2];
  logic  in_frame[2];
  logic  hold_v[2];
  beat_t hold_b[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic mon_one(input int d);
    beat_t got;
    beat_t e;
    int    qs;
    got.d = m_tdata[d];
    got.l = m_tlast[d];
    if (hold_v[d]) begin
      chk($sformatf("hold_valid_dut%0d", d), 32'(m_tvalid[d]), 32'd1);
      chk($sformatf("hold_beat_dut%0d", d), 32'(got), 32'(hold_b[d]));
    end
    if (m_tvalid[d] && m_tready[d]) begin
      qs = (d == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_beat_dut%0d: got data %h last %b with none pending", d, got.d, got.l);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("beat_dut%0d {data,last}", d), 32'(got), 32'(e));
      end
      if (!in_frame[d]) begin
        first_cyc[d] = cyc;
        in_frame[d]  = 1'b1;
      end
      if (got.l) begin
        last_span[d] = cyc - first_cyc[d] + 1;
        in_frame[d]  = 1'b0;
      end
    end
    hold_v[d] = m_tvalid[d] && !m_tready[d];
    hold_b[d] = got;
  endtask

  task automatic push_exp(input int d, input logic [7:0] b, input logic l);
    beat_t e;
    e.d = b;
    e.l = l;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    s_tvalid[d] = 1'b1;
    s_tdata[d]  = b;
    s_tlast[d]  = last;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_tready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      ncmp++;
      nerr++;
      $display("FAIL send_timeout_dut%0d: s_tready stayed 0, required 1", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int d, input logic [7:0] pl[$], input logic [31:0] fcs_const,
                           input bit keep_valid, input int exp_stall);
    logic [7:0]  full[$];
    logic [31:0] fcs;
    int          n;
    full = pl;
    if (d == 1) while (full.size() < MINLEN - 4) full.push_back(8'h00);
    fcs = (fcs_const != 32'h0) ? fcs_const : model_crc(full);
    foreach (full[i]) push_exp(d, full[i], 1'b0);
    for (int k = 0; k < 4; k++) push_exp(d, fcs[8*k +: 8], k == 3);
    foreach (pl[i]) send_byte(d, pl[i], i == pl.size() - 1);
    if (!keep_valid) begin
      s_tvalid[d] = 1'b0;
      s_tlast[d]  = 1'b0;
    end
    if (exp_stall >= 0) begin
      n = 0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (s_tready[d]) break;
        n++;
      end
      chk($sformatf("ready_low_cycles_dut%0d", d), n, exp_stall);
    end
  endtask

  task automatic drain(input int d, input int budget);
    int qs;
    for (int i = 0; i < budget; i++) begin
      qs = (d == 0) ? q0.size() : q1.size();
      if (qs == 0) break;
      @(negedge clk);
    end
    qs = (d == 0) ? q0.size() : q1.size();
    if (qs != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL drain_timeout_dut%0d: %0d bytes still pending, required 0", d, qs);
      if (d == 0) q0.delete();
      else q1.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void build_payload(input int kind, input int len, output logic [7:0] pl[$]);
    pl.delete();
    for (int i = 0; i < len; i++) begin
      case (kind)
        0:       pl.push_back(8'h31 + 8'(i));
        1:       pl.push_back(8'h00);
        default: pl.push_back(8'((i * 37 + 5) & 255));
      endcase
    end
  endfunction

  initial begin
    logic [7:0] pl[$];
    ncmp     = 0;
    nerr     = 0;
    cyc      = 0;
    rand_rdy = 1'b0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_tdata[d]   = 8'h00;
      s_tvalid[d]  = 1'b0;
      s_tlast[d]   = 1'b0;
      first_cyc[d] = 0;
      last_span[d] = 0;
      in_frame[d]  = 1'b0;
      hold_v[d]    = 1'b0;
      hold_b[d]    = '0;
    end

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
          for (int d = 0; d < 2; d++) begin
            hold_v[d]   = 1'b0;
            in_frame[d] = 1'b0;
          end
        end else begin
          mon_one(0);
          mon_one(1);
        end
      end
      begin
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        forever begin
          @(posedge clk);
          #1;
          m_tready[0] = 1'b1;
          m_tready[1] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    join_none

    vecs[0] = '{0, 0, 9,   32'hCBF43926, 13,  4};
    vecs[1] = '{0, 1, 1,   32'hD202EF8D, 5,   4};
    vecs[2] = '{1, 0, 9,   32'h0,        64,  55};
    vecs[3] = '{1, 2, 60,  32'h0,        64,  4};
    vecs[4] = '{1, 2, 100, 32'h0,        104, 4};

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_m_tvalid_dut%0d", d), 32'(m_tvalid[d]), 32'd0);
      chk($sformatf("reset_s_tready_dut%0d", d), 32'(s_tready[d]), 32'd0);
      chk($sformatf("reset_m_tlast_dut%0d", d), 32'(m_tlast[d]), 32'd0);
      chk($sformatf("reset_m_tdata_dut%0d", d), 32'(m_tdata[d]), 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      build_payload(vecs[v].kind, vecs[v].len, pl);
      run_frame(vecs[v].dut, pl, vecs[v].fcs_const, 1'b0, vecs[v].stall);
      drain(vecs[v].dut, 500);
      chk($sformatf("frame_span_vec%0d", v), last_span[vecs[v].dut], vecs[v].span);
    end

    // Back-to-back frames under random backpressure with s_tvalid held high.
    rand_rdy = 1'b1;
    build_payload(2, 1, pl);
    pl[0] = 8'($urandom_range(0, 255));
    run_frame(1, pl, 32'h0, 1'b1, -1);
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_frame(1, pl, 32'h0, 1'b1, -1);
    pl.delete();
    for (int i = 0; i < 70; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_frame(1, pl, 32'h0, 1'b0, -1);
    drain(1, 3000);
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-frame: four bytes reach the output, the fifth is discarded.
    for (int i = 0; i < 4; i++) push_exp(0, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) send_byte(0, 8'hA0 + 8'(i), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_m_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("async_reset_s_tready", 32'(s_tready[0]), 32'd0);
    s_tvalid[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    build_payload(0, 9, pl);
    run_frame(0, pl, 32'hCBF43926, 1'b0, 4);
    drain(0, 500);
    chk("post_reset_frame_span", last_span[0], 13);

    repeat (5) @(negedge clk);
    chk("queue0_empty", q0.size(), 0);
    chk("queue1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
